// File: rtl/fixed_binary_weight_unpacker.sv
// Purpose: unpacks one PACK_WIDTH word of 1-bit weights into IN_SIZE-wide vectors, each repeated NUM_REPEAT times.
// Latency: first vector valid one cycle after the word is accepted; one vector per cycle when downstream is ready.
// Backpressure: weight_ready low freezes the vector and counters; a new word is taken only as the last vector leaves.
module fixed_binary_weight_unpacker #(
  parameter int IN_SIZE      = 4,
  parameter int PACK_WIDTH   = 32,
  parameter int NUM_REPEAT   = 1,
  parameter int WEIGHT_WIDTH = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PACK_WIDTH-1:0]                  packed_in,
  input  logic                                   packed_in_valid,
  output logic                                   packed_in_ready,
  output logic [IN_SIZE-1:0][WEIGHT_WIDTH-1:0]   weight,
  output logic                                   weight_valid,
  input  logic                                   weight_ready
);

  localparam int CHUNKS = PACK_WIDTH / IN_SIZE;
  localparam int K_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int R_W    = (NUM_REPEAT > 1) ? $clog2(NUM_REPEAT) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(CHUNKS - 1);
  localparam logic [R_W-1:0] R_LAST = R_W'(NUM_REPEAT - 1);

  logic [PACK_WIDTH-1:0] held_q, held_d;
  logic                  full_q, full_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [R_W-1:0]        r_q, r_d;

  logic w_hs;
  logic last_hs;
  logic in_hs;

  // Handshake decode: the input opens up in the same cycle the final vector of the held word leaves.
  always_comb begin
    w_hs            = full_q & weight_ready;
    last_hs         = w_hs & (k_q == K_LAST) & (r_q == R_LAST);
    packed_in_ready = ~full_q | last_hs;
    in_hs           = packed_in_valid & packed_in_ready;
    weight_valid    = full_q;
  end

  // Slice select: weight comes only from the held-word register and slice counter.
  always_comb begin
    weight = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      if (k_q == K_W'(c)) begin
        for (int i = 0; i < IN_SIZE; i++) begin
          weight[i] = WEIGHT_WIDTH'(held_q[c*IN_SIZE + i]);
        end
      end
    end
  end

  // Next state: a newly accepted word always wins and restarts the counters; otherwise step r, then k.
  always_comb begin
    held_d = held_q;
    full_d = full_q;
    k_d    = k_q;
    r_d    = r_q;
    if (in_hs) begin
      held_d = packed_in;
      full_d = 1'b1;
      k_d    = '0;
      r_d    = '0;
    end else if (w_hs) begin
      if (r_q == R_LAST) begin
        r_d = '0;
        if (k_q == K_LAST) begin
          k_d    = '0;
          full_d = 1'b0;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end else begin
        r_d = r_q + R_W'(1);
      end
    end
  end

  // State registers; reset discards any partly emitted word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q <= '0;
      full_q <= 1'b0;
      k_q    <= '0;
      r_q    <= '0;
    end else begin
      held_q <= held_d;
      full_q <= full_d;
      k_q    <= k_d;
      r_q    <= r_d;
    end
  end

endmodule

// File: tb/tb_fixed_binary_weight_unpacker.sv
// Purpose: checks two unpacker instances (NUM_REPEAT=1 and 3, IN_SIZE=4, PACK_WIDTH=8) against a queue model.
// Latency: outputs sampled on the falling edge, inputs changed right after sampling.
// Backpressure: random and directed weight_ready stalls; model predicts packed_in_ready from its queue depth.
module tb_fixed_binary_weight_unpacker;

  logic       clk;
  logic       rst;
  logic [7:0] packed_in;
  logic       packed_in_valid;
  logic       weight_ready;

  logic            rdy1, vld1, rdy3, vld3;
  logic [3:0][0:0] w1, w3;

  int checks   = 0;
  int failures = 0;
  int acc1     = 0;

  // Expected vectors still to be emitted for the word each instance holds.
  logic [3:0] mq1[$];
  logic [3:0] mq3[$];

  fixed_binary_weight_unpacker #(.IN_SIZE(4), .PACK_WIDTH(8), .NUM_REPEAT(1), .WEIGHT_WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .packed_in(packed_in), .packed_in_valid(packed_in_valid),
    .packed_in_ready(rdy1), .weight(w1), .weight_valid(vld1), .weight_ready(weight_ready)
  );

  fixed_binary_weight_unpacker #(.IN_SIZE(4), .PACK_WIDTH(8), .NUM_REPEAT(3), .WEIGHT_WIDTH(1)) u_dut3 (
    .clk(clk), .rst(rst), .packed_in(packed_in), .packed_in_valid(packed_in_valid),
    .packed_in_ready(rdy3), .weight(w3), .weight_valid(vld3), .weight_ready(weight_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare both instances against the model queues.
  task automatic mchk();
    chk("vld1", vld1, mq1.size() > 0);
    if (mq1.size() > 0) chk("w1", w1, mq1[0]);
    chk("rdy1", rdy1, (mq1.size() == 0) || (mq1.size() == 1 && weight_ready));
    chk("vld3", vld3, mq3.size() > 0);
    if (mq3.size() > 0) chk("w3", w3, mq3[0]);
    chk("rdy3", rdy3, (mq3.size() == 0) || (mq3.size() == 1 && weight_ready));
  endtask

  // Advance the model over the coming rising edge with the inputs now applied.
  task automatic mupd(input logic v, input logic [7:0] d, input logic wr);
    logic       rdy;
    logic [3:0] s;
    rdy = (mq1.size() == 0) || (mq1.size() == 1 && wr);
    if (mq1.size() > 0 && wr) void'(mq1.pop_front());
    if (v && rdy) begin
      for (int k = 0; k < 2; k++) begin
        s = 4'(d >> (4*k));
        mq1.push_back(s);
      end
      acc1++;
    end
    rdy = (mq3.size() == 0) || (mq3.size() == 1 && wr);
    if (mq3.size() > 0 && wr) void'(mq3.pop_front());
    if (v && rdy) begin
      for (int k = 0; k < 2; k++) begin
        s = 4'(d >> (4*k));
        for (int r = 0; r < 3; r++) mq3.push_back(s);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mchk();
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic wr);
    packed_in_valid = v;
    packed_in       = d;
    weight_ready    = wr;
    mupd(v, d, wr);
  endtask

  task automatic drain();
    repeat (8) begin
      tick();
      drive(1'b0, 8'h00, 1'b1);
    end
  endtask

  int e33[6] = '{3, 3, 3, 12, 12, 12};
  int cyc;

  initial begin
    rst             = 1'b0;
    packed_in       = 8'h00;
    packed_in_valid = 1'b0;
    weight_ready    = 1'b0;
    #1;
    chk("rst_vld1", vld1, 0);
    chk("rst_w1", w1, 0);
    chk("rst_rdy1", rdy1, 1);
    chk("rst_vld3", vld3, 0);
    chk("rst_rdy3", rdy3, 1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1);

    // Single word, no stall.
    tick(); drive(1'b1, 8'hA5, 1'b1);
    tick(); chk("a5_w0", w1, 4'h5); chk("a5_v0", vld1, 1); drive(1'b0, 8'h00, 1'b1);
    tick(); chk("a5_w1", w1, 4'hA); chk("a5_rdy", rdy1, 1); drive(1'b0, 8'h00, 1'b1);
    tick(); chk("a5_end", vld1, 0); drive(1'b0, 8'h00, 1'b1);
    drain();

    // Back-to-back words stream without a gap.
    tick(); drive(1'b1, 8'h12, 1'b1);
    tick(); chk("b2b_0", w1, 4'h2); chk("b2b_rdy0", rdy1, 0); drive(1'b1, 8'h34, 1'b1);
    tick(); chk("b2b_1", w1, 4'h1); chk("b2b_rdy1", rdy1, 1); drive(1'b1, 8'h34, 1'b1);
    tick(); chk("b2b_2", w1, 4'h4); chk("b2b_v2", vld1, 1); drive(1'b0, 8'h00, 1'b1);
    tick(); chk("b2b_3", w1, 4'h3); chk("b2b_v3", vld1, 1); drive(1'b0, 8'h00, 1'b1);
    tick(); chk("b2b_end", vld1, 0); drive(1'b0, 8'h00, 1'b1);
    drain(); drain();

    // Repeat factor three.
    tick(); drive(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(); chk("rep_w", w3, 32'(e33[i])); chk("rep_v", vld3, 1); drive(1'b0, 8'h00, 1'b1);
    end
    tick(); chk("rep_end", vld3, 0); drive(1'b0, 8'h00, 1'b1);
    drain();

    // Downstream stall holds everything.
    tick(); drive(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_w", w1, 4'h5); chk("stall_v", vld1, 1); chk("stall_rdy", rdy1, 0);
      drive(1'b0, 8'h00, (i == 4));
    end
    tick(); chk("stall_a", w1, 4'hA); drive(1'b0, 8'h00, 1'b1);
    drain(); drain();

    // Asynchronous reset in the middle of a word.
    tick(); drive(1'b1, 8'hA5, 1'b1);
    tick(); chk("mid_w", w1, 4'h5);
    packed_in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_vld1", vld1, 0);
    chk("mid_vld3", vld3, 0);
    chk("mid_w0", w1, 0);
    chk("mid_rdy1", rdy1, 1);
    chk("mid_rdy3", rdy3, 1);
    mq1.delete();
    mq3.delete();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    drain();

    // Random traffic with random stalls.
    acc1 = 0;
    cyc  = 0;
    while (acc1 < 1000 && cyc < 20000) begin
      tick();
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("rand_words", acc1, 1000);
    drain(); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_binary_weight_unpacker.md
FIXED_BINARY_WEIGHT_UNPACKER -- requirements
Module: fixed_binary_weight_unpacker

Interface
REQ-001 SHALL have parameter IN_SIZE, default 4: number of 1-bit weights per output vector.
REQ-002 SHALL have parameter PACK_WIDTH, default 32: bits per packed input word; must be a nonzero multiple of IN_SIZE.
REQ-003 SHALL have parameter NUM_REPEAT, default 1: number of times each output vector is emitted; must be >= 1.
REQ-004 SHALL have parameter WEIGHT_WIDTH, default 1: fixed for binary arith, not to be modified.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port packed_in, input, PACK_WIDTH bits: packed binary weights, bit 0 first.
REQ-008 SHALL have port packed_in_valid, input, 1 bit: packed word valid.
REQ-009 SHALL have port packed_in_ready, output, 1 bit: word accepted when valid and ready are both high.
REQ-010 SHALL have port weight, output, array [IN_SIZE-1:0] of WEIGHT_WIDTH bits: weight vector in the same shape as the weight port of the binary vector multiplier.
REQ-011 SHALL have port weight_valid, output, 1 bit: weight vector valid.
REQ-012 SHALL have port weight_ready, input, 1 bit: downstream accepts the vector.

Function
REQ-013 SHALL define CHUNKS = PACK_WIDTH/IN_SIZE and hold at most one packed word in a register with a full flag.
REQ-014 SHALL track slice index k (0..CHUNKS-1) and repeat index r (0..NUM_REPEAT-1).
REQ-015 SHALL drive weight[i] = held_word[IN_SIZE*k + i] for all i.
REQ-016 SHALL drive weight_valid = full; weight SHALL be driven only from registers, with no combinational path from packed_in.
REQ-017 SHALL, on each weight handshake: increment r; when r wraps, clear r and increment k; when k also wraps, the word is consumed.
REQ-018 SHALL drive packed_in_ready = !full OR (weight handshake on k=CHUNKS-1, r=NUM_REPEAT-1), so that back-to-back words stream with zero bubble cycles.
REQ-019 SHALL, when a word is accepted, load it, set full, and clear k and r; first weight_valid follows one cycle after acceptance.
REQ-020 SHALL, when consuming the last slice and accepting a new word in the same cycle, load the new word, keep full set, and reset the counters.
REQ-021 SHALL, when the last slice is consumed without a new word, clear full.
REQ-022 SHALL keep weight, weight_valid, k and r stable while weight_valid=1 and weight_ready=0.
REQ-023 SHALL sustain throughput of one weight vector per cycle under no backpressure; each word occupies CHUNKS*NUM_REPEAT handshakes.
REQ-024 SHALL ignore packed_in and packed_in_valid while packed_in_ready=0.

Reset
REQ-025 SHALL, on rst low, asynchronously clear full, k and r and zero the held word.
REQ-026 SHALL therefore drive weight_valid=0, weight all zero and packed_in_ready=1 while in reset.
REQ-027 SHALL, on reset mid-word, discard the held word with no later emission of any of its remaining slices.

Structure
REQ-028 SHALL need no shared package; CHUNKS and the counter widths ($clog2, minimum 1 bit) SHALL be module localparams.
REQ-029 SHALL be a single module with no sub-module instances; the held-word register, counters and full flag are inline.
REQ-030 SHALL be usable directly as the driver of the weight/weight_valid/weight_ready port of fixed_activation_binary_vector_mult.

Verification
(Configuration for all scenarios: IN_SIZE=4, PACK_WIDTH=8.)
REQ-031 SHALL cover: NUM_REPEAT=1, word 0xA5 at cycle t, weight_ready=1 -> weight 0x5 at t+1, 0xA at t+2; packed_in_ready=1 at t+2.
REQ-032 SHALL cover: NUM_REPEAT=1, back-to-back words 0x12, 0x34, weight_ready=1 -> weight sequence 0x2, 0x1, 0x4, 0x3 on consecutive cycles with no gap.
REQ-033 SHALL cover: NUM_REPEAT=3, word 0xC3 -> weight 0x3, 0x3, 0x3, 0xC, 0xC, 0xC, then weight_valid=0.
REQ-034 SHALL cover: word 0xA5 with weight_ready held low for 5 cycles -> weight stays 0x5, weight_valid=1 and packed_in_ready=0 throughout; after release, 0x5 then 0xA.
REQ-035 SHALL cover: rst asserted after the 0x5 slice of 0xA5 is emitted -> weight_valid drops without waiting for a clock edge; after release packed_in_ready=1 and 0xA is never emitted.
REQ-036 SHALL cover: a random-stall scoreboard run of 1000 words against a reference unpack -> exact sequence match and no protocol violations.
